// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR unit.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [2:0] FUNCT3_CSRRW  = 3'b001;
  localparam logic [2:0] FUNCT3_CSRRS  = 3'b010;
  localparam logic [2:0] FUNCT3_CSRRC  = 3'b011;
  localparam logic [2:0] FUNCT3_CSRRWI = 3'b101;
  localparam logic [2:0] FUNCT3_CSRRSI = 3'b110;
  localparam logic [2:0] FUNCT3_CSRRCI = 3'b111;

  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_MEI = 5'd11;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  typedef enum logic {
    RUN   = 1'b0,
    SLEEP = 1'b1
  } csr_state_e;

  // Interrupt line index to cause code / mip bit position.
  function automatic logic [4:0] irq_cause(input int unsigned idx);
    case (idx)
      0:       return CAUSE_MEI;
      1:       return CAUSE_MTI;
      default: return CAUSE_MSI;
    endcase
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Read-modify-write datapath for CSRRW/S/C and their immediate forms.
module csr_rmw_alu
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] src1,
  input  logic [4:0]      zimm,
  input  logic [2:0]      func3,
  input  logic            src_is_x0,
  output logic [XLEN-1:0] new_val,
  output logic            we
);

  logic [XLEN-1:0] operand;

  // Set/clear with a zero source is a pure read and must not write.
  always_comb begin
    operand = func3[2] ? XLEN'(zimm) : src1;
    new_val = old_val;
    we      = 1'b0;
    case (func3)
      FUNCT3_CSRRW, FUNCT3_CSRRWI: begin
        new_val = operand;
        we      = 1'b1;
      end
      FUNCT3_CSRRS, FUNCT3_CSRRSI: begin
        new_val = old_val | operand;
        we      = ~src_is_x0;
      end
      FUNCT3_CSRRC, FUNCT3_CSRRCI: begin
        new_val = old_val & ~operand;
        we      = ~src_is_x0;
      end
      default: begin
        new_val = old_val;
        we      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: registers, counters, interrupt/trap entry, MRET and WFI sleep.
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     NUM_IRQ      = 2,
  parameter logic [XLEN-1:0] MTVEC_RST    = XLEN'(32'h0001_0000),
  parameter int unsigned     HAS_COUNTERS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_en,
  input  logic [2:0]         csr_func3,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    src1,
  input  logic [4:0]         zimm,
  input  logic               src_is_x0,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_illegal,
  input  logic [XLEN-1:0]    pc_ex,
  input  logic               retire,
  input  logic               mret,
  input  logic               wfi,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               redirect,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               stall_req
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam bit              CNT_ON     = (HAS_COUNTERS != 0);

  csr_state_e      state_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mepc_q, mcause_q, mscratch_q;
  logic            mstatus_mie_q, mstatus_mpie_q;
  logic [63:0]     mcycle_q, minstret_q;

  logic [XLEN-1:0] irq_mask, mip_val, mstatus_val, pending, old_val, new_val;
  logic            addr_known, alu_we, illegal, wr, take, do_mret;
  logic [4:0]      trap_cause;
  logic [63:0]     mcycle_d, minstret_d;

  // Map the interrupt lines onto their mip/mie bit positions.
  always_comb begin
    irq_mask = '0;
    mip_val  = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      irq_mask[irq_cause(i)] = 1'b1;
      mip_val[irq_cause(i)]  = irq[i];
    end
  end

  always_comb begin
    mstatus_val                                = '0;
    mstatus_val[MSTATUS_MIE]                   = mstatus_mie_q;
    mstatus_val[MSTATUS_MPIE]                  = mstatus_mpie_q;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  assign pending = mip_val & mie_q;

  // Priority encoder: MEI over MSI over MTI.
  always_comb begin
    if (pending[CAUSE_MEI])      trap_cause = CAUSE_MEI;
    else if (pending[CAUSE_MSI]) trap_cause = CAUSE_MSI;
    else                         trap_cause = CAUSE_MTI;
  end

  assign take    = (state_q == RUN) && (|pending) && mstatus_mie_q;
  assign do_mret = (state_q == RUN) && mret && !take;

  always_comb begin
    old_val    = '0;
    addr_known = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   old_val = mstatus_val;
      CSR_MIE:       old_val = mie_q;
      CSR_MIP:       old_val = mip_val;
      CSR_MTVEC:     old_val = mtvec_q;
      CSR_MEPC:      old_val = mepc_q;
      CSR_MCAUSE:    old_val = mcause_q;
      CSR_MSCRATCH:  old_val = mscratch_q;
      CSR_MCYCLE:    old_val = CNT_ON ? XLEN'(mcycle_q[31:0])    : '0;
      CSR_MCYCLEH:   old_val = CNT_ON ? XLEN'(mcycle_q[63:32])   : '0;
      CSR_MINSTRET:  old_val = CNT_ON ? XLEN'(minstret_q[31:0])  : '0;
      CSR_MINSTRETH: old_val = CNT_ON ? XLEN'(minstret_q[63:32]) : '0;
      default: begin
        old_val    = '0;
        addr_known = 1'b0;
      end
    endcase
  end

  csr_rmw_alu #(.XLEN(XLEN)) u_rmw_alu (
    .old_val   (old_val),
    .src1      (src1),
    .zimm      (zimm),
    .func3     (csr_func3),
    .src_is_x0 (src_is_x0),
    .new_val   (new_val),
    .we        (alu_we)
  );

  // A trap drops the instruction in this stage; it is replayed after the handler.
  assign illegal = csr_en && (!addr_known || (alu_we && csr_addr == CSR_MIP));
  assign wr      = csr_en && alu_we && !illegal && !take;

  assign csr_rdata   = (csr_en && !rst) ? old_val : '0;
  assign csr_illegal = illegal && !take && !rst;
  assign redirect    = (take || do_mret) && !rst;
  assign redirect_pc = take ? mtvec_q : mepc_q;
  assign stall_req   = (state_q == SLEEP) && !(|pending) && !rst;

  // Counters: increment, then let a CSR write to either half override it.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + 64'(retire);
    if (wr) begin
      case (csr_addr)
        CSR_MCYCLE:    mcycle_d[31:0]    = new_val[31:0];
        CSR_MCYCLEH:   mcycle_d[63:32]   = new_val[31:0];
        CSR_MINSTRET:  minstret_d[31:0]  = new_val[31:0];
        CSR_MINSTRETH: minstret_d[63:32] = new_val[31:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RST & ALIGN_MASK;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mscratch_q     <= '0;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      if (wr) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie_q  <= new_val[MSTATUS_MIE];
            mstatus_mpie_q <= new_val[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_q      <= new_val & irq_mask;
          CSR_MTVEC:    mtvec_q    <= new_val & ALIGN_MASK;
          CSR_MEPC:     mepc_q     <= new_val & ALIGN_MASK;
          CSR_MCAUSE:   mcause_q   <= new_val;
          CSR_MSCRATCH: mscratch_q <= new_val;
          default: ;
        endcase
      end

      if (take) begin
        mepc_q         <= pc_ex & ALIGN_MASK;
        mcause_q       <= {1'b1, (XLEN-1)'(trap_cause)};
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (do_mret) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end

      if (CNT_ON) begin
        mcycle_q   <= mcycle_d;
        minstret_q <= minstret_d;
      end

      // Sleep only when nothing is pending; wake on any enabled pending irq.
      case (state_q)
        RUN:     if (wfi && !(|pending)) state_q <= SLEEP;
        SLEEP:   if (|pending)           state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: table of CSR accesses plus trap, MRET, counter and WFI sequences.
module tb_csr_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en;
  logic [2:0]  csr_func3;
  logic [11:0] csr_addr;
  logic [31:0] src1;
  logic [4:0]  zimm;
  logic        src_is_x0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [31:0] pc_ex;
  logic        retire;
  logic        mret;
  logic        wfi;
  logic [1:0]  irq;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_unit dut (
    .clk         (clk),
    .rst         (rst),
    .csr_en      (csr_en),
    .csr_func3   (csr_func3),
    .csr_addr    (csr_addr),
    .src1        (src1),
    .zimm        (zimm),
    .src_is_x0   (src_is_x0),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .pc_ex       (pc_ex),
    .retire      (retire),
    .mret        (mret),
    .wfi         (wfi),
    .irq         (irq),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall_req   (stall_req)
  );

  typedef struct {
    string       name;
    logic        en;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] src;
    logic [4:0]  z;
    logic        x0;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [2:0] f3, input logic [11:0] a,
                       input logic [31:0] s, input logic [4:0] z, input logic x0);
    csr_en    = en;
    csr_func3 = f3;
    csr_addr  = a;
    src1      = s;
    zimm      = z;
    src_is_x0 = x0;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 12'h000, 32'h0, 5'h0, 1'b0);
  endtask

  // Read a CSR without side effects and compare, then advance one cycle.
  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    drive(1'b1, FUNCT3_CSRRS, a, 32'h0, 5'h0, 1'b1);
    #2;
    chk(name, csr_rdata, exp);
    @(negedge clk);
  endtask

  task automatic wr_rw(input logic [11:0] a, input logic [31:0] v);
    drive(1'b1, FUNCT3_CSRRW, a, v, 5'h0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    vecs.push_back('{"mtvec_rw",     1'b1, FUNCT3_CSRRW,  CSR_MTVEC,    32'h2000,     5'h00, 1'b0, 32'h0001_0000, 1'b0});
    vecs.push_back('{"mtvec_new",    1'b1, FUNCT3_CSRRS,  CSR_MTVEC,    32'h0,        5'h00, 1'b1, 32'h0000_2000, 1'b0});
    vecs.push_back('{"mscr_rwi",     1'b1, FUNCT3_CSRRWI, CSR_MSCRATCH, 32'h0,        5'h15, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{"mscr_rsi",     1'b1, FUNCT3_CSRRSI, CSR_MSCRATCH, 32'h0,        5'h0A, 1'b0, 32'h15,        1'b0});
    vecs.push_back('{"mscr_rci",     1'b1, FUNCT3_CSRRCI, CSR_MSCRATCH, 32'h0,        5'h03, 1'b0, 32'h1F,        1'b0});
    vecs.push_back('{"mscr_rd",      1'b1, FUNCT3_CSRRS,  CSR_MSCRATCH, 32'hFFFF,     5'h00, 1'b1, 32'h1C,        1'b0});
    vecs.push_back('{"mip_rw",       1'b1, FUNCT3_CSRRW,  CSR_MIP,      32'h5,        5'h00, 1'b0, 32'h0,         1'b1});
    vecs.push_back('{"mip_rs_x0",    1'b1, FUNCT3_CSRRS,  CSR_MIP,      32'h0,        5'h00, 1'b1, 32'h0,         1'b0});
    vecs.push_back('{"mie_rw",       1'b1, FUNCT3_CSRRW,  CSR_MIE,      32'hFFFFFFFF, 5'h00, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{"mie_rc",       1'b1, FUNCT3_CSRRC,  CSR_MIE,      32'h80,       5'h00, 1'b0, 32'h880,       1'b0});
    vecs.push_back('{"mie_rd",       1'b1, FUNCT3_CSRRS,  CSR_MIE,      32'h0,        5'h00, 1'b1, 32'h800,       1'b0});
    vecs.push_back('{"mstatus_rst",  1'b1, FUNCT3_CSRRS,  CSR_MSTATUS,  32'h0,        5'h00, 1'b1, 32'h1800,      1'b0});
    vecs.push_back('{"unknown_addr", 1'b1, FUNCT3_CSRRW,  12'h7C0,      32'h1,        5'h00, 1'b0, 32'h0,         1'b1});
    vecs.push_back('{"mepc_rw",      1'b1, FUNCT3_CSRRW,  CSR_MEPC,     32'h147,      5'h00, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{"mepc_align",   1'b1, FUNCT3_CSRRS,  CSR_MEPC,     32'h0,        5'h00, 1'b1, 32'h144,       1'b0});
    vecs.push_back('{"mtvec_keep",   1'b1, FUNCT3_CSRRS,  CSR_MTVEC,    32'h0,        5'h00, 1'b1, 32'h2000,      1'b0});
    vecs.push_back('{"no_en",        1'b0, FUNCT3_CSRRW,  CSR_MTVEC,    32'h0,        5'h00, 1'b0, 32'h0,         1'b0});

    rst = 1'b1; pc_ex = 32'h0; retire = 1'b0; mret = 1'b0; wfi = 1'b0; irq = 2'b00;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_rdata", csr_rdata, 32'h0);
    chk("rst_illegal", 32'(csr_illegal), 32'h0);
    chk("rst_redirect", 32'(redirect), 32'h0);
    chk("rst_stall", 32'(stall_req), 32'h0);
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].f3, vecs[i].addr, vecs[i].src, vecs[i].z, vecs[i].x0);
      #2;
      chk({vecs[i].name, "_rdata"}, csr_rdata, vecs[i].exp_rdata);
      chk({vecs[i].name, "_ill"}, 32'(csr_illegal), 32'(vecs[i].exp_ill));
      @(negedge clk);
    end

    // Trap entry on MEI with a concurrent mscratch write that must be dropped.
    wr_rw(CSR_MSTATUS, 32'h8);
    irq = 2'b01; pc_ex = 32'h140;
    drive(1'b1, FUNCT3_CSRRW, CSR_MSCRATCH, 32'hDEAD, 5'h0, 1'b0);
    #2;
    chk("trap_redirect", 32'(redirect), 32'h1);
    chk("trap_pc", redirect_pc, 32'h2000);
    chk("trap_no_illegal", 32'(csr_illegal), 32'h0);
    @(negedge clk);
    irq = 2'b00;
    rd("trap_mepc", CSR_MEPC, 32'h140);
    rd("trap_mcause", CSR_MCAUSE, 32'h8000_000B);
    rd("trap_mstatus", CSR_MSTATUS, 32'h1880);
    rd("trap_dropped_wr", CSR_MSCRATCH, 32'h1C);

    // MRET with the IRQ still asserted: return now, re-trap on the next cycle.
    idle();
    mret = 1'b1; irq = 2'b01;
    #2;
    chk("mret_redirect", 32'(redirect), 32'h1);
    chk("mret_pc", redirect_pc, 32'h140);
    @(negedge clk);
    mret = 1'b0; pc_ex = 32'h144;
    #2;
    chk("retrap_redirect", 32'(redirect), 32'h1);
    chk("retrap_pc", redirect_pc, 32'h2000);
    @(negedge clk);
    irq = 2'b00;
    #2;
    chk("post_retrap_redirect", 32'(redirect), 32'h0);
    @(negedge clk);
    rd("retrap_mepc", CSR_MEPC, 32'h144);
    rd("retrap_mstatus", CSR_MSTATUS, 32'h1880);

    // 64-bit cycle counter carry and write-wins behaviour.
    wr_rw(CSR_MCYCLEH, 32'h0);
    wr_rw(CSR_MCYCLE, 32'hFFFF_FFFF);
    rd("mcycle_max", CSR_MCYCLE, 32'hFFFF_FFFF);
    rd("mcycle_wrap", CSR_MCYCLE, 32'h0);
    rd("mcycleh_carry", CSR_MCYCLEH, 32'h1);
    drive(1'b1, FUNCT3_CSRRW, CSR_MCYCLE, 32'h5, 5'h0, 1'b0);
    #2;
    chk("mcycle_old", csr_rdata, 32'h2);
    @(negedge clk);
    rd("mcycle_write_wins", CSR_MCYCLE, 32'h5);

    retire = 1'b1;
    wr_rw(CSR_MINSTRET, 32'h10);
    idle();
    repeat (3) @(negedge clk);
    retire = 1'b0;
    rd("minstret_count", CSR_MINSTRET, 32'h13);

    // WFI with MIE=0 and MTIE=1: sleep, then wake on MTI without a trap.
    drive(1'b1, FUNCT3_CSRRS, CSR_MIE, 32'h80, 5'h0, 1'b0);
    @(negedge clk);
    idle();
    wfi = 1'b1;
    #2;
    chk("wfi_cycle_stall", 32'(stall_req), 32'h0);
    @(negedge clk);
    wfi = 1'b0;
    begin
      int stall_cnt = 0;
      for (int i = 0; i < 10; i++) begin
        #2;
        if (stall_req === 1'b1) stall_cnt++;
        @(negedge clk);
      end
      chk("sleep_stall_cycles", 32'(stall_cnt), 32'd10);
    end
    irq = 2'b10;
    #2;
    chk("wake_stall", 32'(stall_req), 32'h0);
    chk("wake_redirect", 32'(redirect), 32'h0);
    @(negedge clk);
    #2;
    chk("resume_stall", 32'(stall_req), 32'h0);
    chk("resume_no_trap", 32'(redirect), 32'h0);
    @(negedge clk);
    wfi = 1'b1;
    @(negedge clk);
    wfi = 1'b0;
    #2;
    chk("wfi_pending_nop", 32'(stall_req), 32'h0);
    @(negedge clk);
    rd("wfi_mcause_kept", CSR_MCAUSE, 32'h8000_000B);

    // Reset while asleep returns to RUN with CSRs back at reset values.
    irq = 2'b00; idle(); wfi = 1'b1;
    @(negedge clk);
    wfi = 1'b0;
    #2;
    chk("sleep_again", 32'(stall_req), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rst_sleep_stall", 32'(stall_req), 32'h0);
    chk("rst_sleep_redirect", 32'(redirect), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("post_rst_stall", 32'(stall_req), 32'h0);
    @(negedge clk);
    rd("post_rst_mtvec", CSR_MTVEC, 32'h0001_0000);
    rd("post_rst_mie", CSR_MIE, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
